keccak_rate_tracker: RTL and testbench

Sequential successor to the combinational mode/parameter decode. Latches the Keccak mode at message start, tracks the absorb byte offset within the rate block, and requests permutations when a block fills. At end of message it emits the padding positions and sequences the final permutation. It sits between the input stream interface and the sponge datapath/permutation core, and supports all six SHA-3/SHAKE modes on a configurable beat width.

---
 rtl/keccak_rate_tracker.sv | 164 ++++++++++++++++
 tb/tb_keccak_rate_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/keccak_rate_tracker.sv
// Keccak sponge rate tracker: latches mode parameters at message start, tracks the
// absorb offset inside the rate block, sequences permutations and emits padding info.
module keccak_rate_tracker #(
    parameter int DATA_BYTES = 8,
    parameter int CNT_W      = 16,
    localparam int BW        = $clog2(DATA_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [2:0]       keccak_mode_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [BW-1:0]    in_bytes_i,
    input  logic             in_last_i,
    output logic [7:0]       byte_offset_o,
    output logic [7:0]       rate_bytes_o,
    output logic [7:0]       suffix_o,
    output logic             perm_req_o,
    input  logic             perm_done_i,
    output logic             pad_valid_o,
    output logic [7:0]       pad_pos_o,
    output logic             pad_merged_o,
    output logic             done_o,
    output logic             mode_err_o,
    output logic [CNT_W-1:0] perm_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_ABSORB       = 3'd1,
        S_PERM         = 3'd2,
        S_PERM_PRE_PAD = 3'd3,
        S_PAD          = 3'd4,
        S_PERM_FINAL   = 3'd5
    } state_t;

    function automatic logic [7:0] rate_of(input logic [2:0] mode);
        logic [7:0] rate;
        case (mode)
            3'd0:    rate = 8'd144;
            3'd1:    rate = 8'd136;
            3'd2:    rate = 8'd104;
            3'd3:    rate = 8'd72;
            3'd4:    rate = 8'd168;
            3'd5:    rate = 8'd136;
            default: rate = 8'd0;
        endcase
        return rate;
    endfunction

    function automatic logic mode_ok(input logic [2:0] mode);
        return (mode <= 3'd5);
    endfunction

    function automatic logic [7:0] suffix_of(input logic [2:0] mode);
        return (mode >= 3'd4) ? 8'h1F : 8'h06;
    endfunction

    state_t           r_state;
    logic [7:0]       r_offset;
    logic [7:0]       r_rate;
    logic [7:0]       r_suffix;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_mode_err;

    logic [8:0]       w_next;
    logic             w_full;
    logic [CNT_W-1:0] w_cnt_inc;

    // Next absorb offset, block-full detect and saturating counter increment.
    always_comb begin
        w_next = {1'b0, r_offset} + {{(9 - BW){1'b0}}, in_bytes_i};
        w_full = (w_next == {1'b0, r_rate});
        if (&r_cnt) begin
            w_cnt_inc = r_cnt;
        end else begin
            w_cnt_inc = r_cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
        end
    end

    // Control FSM; abort wins over everything but leaves latched values untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_offset   <= 8'd0;
            r_rate     <= 8'd0;
            r_suffix   <= 8'd0;
            r_cnt      <= {CNT_W{1'b0}};
            r_done     <= 1'b0;
            r_mode_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_mode_err <= 1'b0;
            if (abort_i) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            if (mode_ok(keccak_mode_i)) begin
                                r_rate   <= rate_of(keccak_mode_i);
                                r_suffix <= suffix_of(keccak_mode_i);
                                r_offset <= 8'd0;
                                r_cnt    <= {CNT_W{1'b0}};
                                r_state  <= S_ABSORB;
                            end else begin
                                r_mode_err <= 1'b1;
                            end
                        end
                    end
                    S_ABSORB: begin
                        if (in_valid_i) begin
                            if (w_full) begin
                                r_offset <= 8'd0;
                                r_state  <= in_last_i ? S_PERM_PRE_PAD : S_PERM;
                            end else begin
                                r_offset <= w_next[7:0];
                                if (in_last_i) begin
                                    r_state <= S_PAD;
                                end
                            end
                        end
                    end
                    S_PERM, S_PERM_PRE_PAD: begin
                        if (perm_done_i) begin
                            r_cnt   <= w_cnt_inc;
                            r_state <= (r_state == S_PERM) ? S_ABSORB : S_PAD;
                        end
                    end
                    S_PAD: begin
                        r_state <= S_PERM_FINAL;
                    end
                    S_PERM_FINAL: begin
                        if (perm_done_i) begin
                            r_cnt   <= w_cnt_inc;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready_o    = (r_state == S_ABSORB);
    assign perm_req_o    = (r_state == S_PERM) || (r_state == S_PERM_PRE_PAD) ||
                           (r_state == S_PERM_FINAL);
    assign pad_valid_o   = (r_state == S_PAD);
    assign pad_pos_o     = (r_state == S_PAD) ? r_offset : 8'd0;
    assign pad_merged_o  = (r_state == S_PAD) && (r_offset == (r_rate - 8'd1));
    assign byte_offset_o = r_offset;
    assign rate_bytes_o  = r_rate;
    assign suffix_o      = r_suffix;
    assign perm_cnt_o    = r_cnt;
    assign done_o        = r_done;
    assign mode_err_o    = r_mode_err;

endmodule

// File: tb/tb_keccak_rate_tracker.sv
// Directed bench for keccak_rate_tracker: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_keccak_rate_tracker;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [2:0]  keccak_mode_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  in_bytes_i;
    logic        in_last_i;
    logic [7:0]  byte_offset_o;
    logic [7:0]  rate_bytes_o;
    logic [7:0]  suffix_o;
    logic        perm_req_o;
    logic        perm_done_i;
    logic        pad_valid_o;
    logic [7:0]  pad_pos_o;
    logic        pad_merged_o;
    logic        done_o;
    logic        mode_err_o;
    logic [15:0] perm_cnt_o;

    int total = 0;
    int bad   = 0;

    keccak_rate_tracker #(.DATA_BYTES(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .keccak_mode_i(keccak_mode_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_bytes_i(in_bytes_i), .in_last_i(in_last_i), .byte_offset_o(byte_offset_o),
        .rate_bytes_o(rate_bytes_o), .suffix_o(suffix_o), .perm_req_o(perm_req_o),
        .perm_done_i(perm_done_i), .pad_valid_o(pad_valid_o), .pad_pos_o(pad_pos_o),
        .pad_merged_o(pad_merged_o), .done_o(done_o), .mode_err_o(mode_err_o),
        .perm_cnt_o(perm_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_msg(input logic [2:0] mode);
        start_i       = 1'b1;
        keccak_mode_i = mode;
        tick();
        start_i       = 1'b0;
        keccak_mode_i = 3'd7;
    endtask

    task automatic beat(input logic [3:0] nb, input logic last);
        in_valid_i = 1'b1;
        in_bytes_i = nb;
        in_last_i  = last;
        tick();
        in_valid_i = 1'b0;
        in_bytes_i = 4'd0;
        in_last_i  = 1'b0;
    endtask

    task automatic perm_ack();
        perm_done_i = 1'b1;
        tick();
        perm_done_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; keccak_mode_i = 3'd0;
        in_valid_i = 1'b0; in_bytes_i = 4'd0; in_last_i = 1'b0; perm_done_i = 1'b0;
        #12;
        chk("rst_ready", in_ready_o, 32'd0);
        chk("rst_rate", rate_bytes_o, 32'd0);
        chk("rst_suffix", suffix_o, 32'd0);
        chk("rst_req", perm_req_o, 32'd0);
        chk("rst_cnt", perm_cnt_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // SHA3_256: 24 + 3 bytes -> pad at 27
        start_msg(3'd1);
        chk("t1_ready", in_ready_o, 32'd1);
        chk("t1_rate", rate_bytes_o, 32'd136);
        chk("t1_suffix", suffix_o, 32'h06);
        for (int i = 0; i < 3; i++) beat(4'd8, 1'b0);
        chk("t1_off24", byte_offset_o, 32'd24);
        beat(4'd3, 1'b1);
        chk("t1_padv", pad_valid_o, 32'd1);
        chk("t1_padpos", pad_pos_o, 32'd27);
        chk("t1_merged", pad_merged_o, 32'd0);
        chk("t1_ready_pad", in_ready_o, 32'd0);
        tick();
        chk("t1_padv_once", pad_valid_o, 32'd0);
        chk("t1_req", perm_req_o, 32'd1);
        perm_ack();
        chk("t1_done", done_o, 32'd1);
        chk("t1_cnt", perm_cnt_o, 32'd1);
        chk("t1_req_drop", perm_req_o, 32'd0);
        tick();
        chk("t1_done_pulse", done_o, 32'd0);
        chk("t1_rate_hold", rate_bytes_o, 32'd136);

        // SHAKE128: 168 bytes ending on the block boundary
        start_msg(3'd4);
        chk("t2_rate", rate_bytes_o, 32'd168);
        chk("t2_suffix", suffix_o, 32'h1F);
        for (int i = 0; i < 20; i++) beat(4'd8, 1'b0);
        chk("t2_off160", byte_offset_o, 32'd160);
        beat(4'd8, 1'b1);
        chk("t2_prepad_req", perm_req_o, 32'd1);
        chk("t2_prepad_nopad", pad_valid_o, 32'd0);
        chk("t2_off0", byte_offset_o, 32'd0);
        tick();
        chk("t2_req_held", perm_req_o, 32'd1);
        perm_ack();
        chk("t2_padv", pad_valid_o, 32'd1);
        chk("t2_padpos", pad_pos_o, 32'd0);
        chk("t2_cnt1", perm_cnt_o, 32'd1);
        tick();
        perm_ack();
        chk("t2_done", done_o, 32'd1);
        chk("t2_cnt2", perm_cnt_o, 32'd2);

        // SHA3_512: 64 + 7 bytes -> merged padding at 71
        start_msg(3'd3);
        chk("t3_rate", rate_bytes_o, 32'd72);
        for (int i = 0; i < 8; i++) beat(4'd8, 1'b0);
        beat(4'd7, 1'b1);
        chk("t3_padpos", pad_pos_o, 32'd71);
        chk("t3_merged", pad_merged_o, 32'd1);
        tick();
        perm_ack();
        chk("t3_done", done_o, 32'd1);
        chk("t3_cnt", perm_cnt_o, 32'd1);

        // SHA3_224 empty message
        start_msg(3'd0);
        chk("t4_rate", rate_bytes_o, 32'd144);
        beat(4'd0, 1'b1);
        chk("t4_padv", pad_valid_o, 32'd1);
        chk("t4_padpos", pad_pos_o, 32'd0);
        chk("t4_merged", pad_merged_o, 32'd0);
        tick();
        perm_ack();
        chk("t4_done", done_o, 32'd1);
        chk("t4_cnt", perm_cnt_o, 32'd1);

        // invalid mode, then SHAKE256, then abort from ABSORB
        start_msg(3'd6);
        chk("t5_err", mode_err_o, 32'd1);
        chk("t5_ready", in_ready_o, 32'd0);
        chk("t5_rate_hold", rate_bytes_o, 32'd144);
        tick();
        chk("t5_err_pulse", mode_err_o, 32'd0);
        chk("t5_idle", in_ready_o, 32'd0);
        start_msg(3'd5);
        chk("t5_err_valid", mode_err_o, 32'd0);
        chk("t5_rate", rate_bytes_o, 32'd136);
        chk("t5_suffix", suffix_o, 32'h1F);
        chk("t5_ready2", in_ready_o, 32'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t5_abort_idle", in_ready_o, 32'd0);

        // SHA3_384: abort during PERM, then a minimal zero-wait message
        start_msg(3'd2);
        chk("t6_rate", rate_bytes_o, 32'd104);
        for (int i = 0; i < 12; i++) beat(4'd8, 1'b0);
        beat(4'd8, 1'b0);
        chk("t6_req", perm_req_o, 32'd1);
        chk("t6_notready", in_ready_o, 32'd0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t6_abort_req", perm_req_o, 32'd0);
        chk("t6_abort_done", done_o, 32'd0);
        chk("t6_abort_cnt", perm_cnt_o, 32'd0);
        chk("t6_abort_ready", in_ready_o, 32'd0);
        perm_done_i = 1'b1;
        tick();
        chk("t6_idle_done_ign", done_o, 32'd0);
        chk("t6_idle_cnt_ign", perm_cnt_o, 32'd0);
        start_msg(3'd2);
        chk("t6_ready", in_ready_o, 32'd1);
        chk("t6_cnt_clr", perm_cnt_o, 32'd0);
        beat(4'd5, 1'b1);
        chk("t6_padpos", pad_pos_o, 32'd5);
        chk("t6_pad_cnt", perm_cnt_o, 32'd0);
        tick();
        chk("t6_final_req", perm_req_o, 32'd1);
        tick();
        perm_done_i = 1'b0;
        chk("t6_done", done_o, 32'd1);
        chk("t6_cnt", perm_cnt_o, 32'd1);
        chk("t6_idle", perm_req_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
